// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

   localparam logic [31:0] PC_STEP     = 32'd4;
   localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } ifid_t;

endpackage

// File: rtl/instr_fetch_ifid_reg.sv
// IF/ID pipeline register: holds unless loaded; a squashing load writes the bubble.
module ifid_reg
   import if_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  logic  squash,
   input  ifid_t d,
   output ifid_t q
);

   ifid_t bubble;

   always_comb begin
      bubble       = '0;
      bubble.instr = NOP_INSTR;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= bubble;
      end else if (load) begin
         q <= squash ? bubble : d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, redirect/stall/flush control and IF/ID capture.
// Optional out-of-range fetch trap enabled by defining IF_RANGE_CHECK_EN.
module instr_fetch
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 128,
   parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] pc,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic        fetch_fault
);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc_nxt;
   logic [31:0]  pc_plus4;
   logic         ld;
   logic         sq;
   logic         range_hit;
   logic         fault_set;
   ifid_t        ifid_d;
   ifid_t        ifid_q;

   assign imem_addr = {2'b00, pc[31:2]};
   assign pc_plus4  = pc + PC_STEP;

`ifdef IF_RANGE_CHECK_EN
   assign range_hit = ({2'b00, pc[31:2]} >= 32'(IMEM_DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_fault <= 1'b0;
      end else if (fault_set) begin
         fetch_fault <= 1'b1;
      end
   end
`else
   assign range_hit   = 1'b0;
   assign fetch_fault = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // Priority in RUN: redirect > stall > range trap > flush > normal capture.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ld        = 1'b0;
      sq        = 1'b0;
      fault_set = 1'b0;
      unique case (state)
         RUN: begin
            if (redirect_valid) begin
               pc_nxt = {redirect_pc[31:2], 2'b00};
               ld     = 1'b1;
               sq     = 1'b1;
            end else if (!stall) begin
               if (range_hit) begin
                  ld        = 1'b1;
                  sq        = 1'b1;
                  fault_set = 1'b1;
                  state_nxt = HALT;
               end else begin
                  pc_nxt = pc_plus4;
                  ld     = 1'b1;
                  sq     = flush;
               end
            end
         end
         HALT: begin
            ld = 1'b1;
            sq = 1'b1;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   always_comb begin
      ifid_d       = '0;
      ifid_d.instr = imem_data;
      ifid_d.pc4   = pc_plus4;
      ifid_d.valid = 1'b1;
   end

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid (
      .clk    (clk),
      .rst    (rst),
      .load   (ld),
      .squash (sq),
      .d      (ifid_d),
      .q      (ifid_q)
   );

   assign ifid_instr = ifid_q.instr;
   assign ifid_pc4   = ifid_q.pc4;
   assign ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch; memory word i holds value i.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] pc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        fetch_fault;

   int checks = 0;
   int failures = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   assign imem_data = imem_addr;

   instr_fetch #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_DEPTH (128),
      .NOP_INSTR  (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .pc             (pc),
      .ifid_instr     (ifid_instr),
      .ifid_pc4       (ifid_pc4),
      .ifid_valid     (ifid_valid),
      .fetch_fault    (fetch_fault)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: rules applied directly on the architectural values.
   logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0;
   logic        m_valid = 1'b0, m_fault = 1'b0, m_halt = 1'b0;
   bit          oob;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
         m_valid = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
      end else if (!m_halt) begin
`ifdef IF_RANGE_CHECK_EN
         oob = (m_pc / 4) >= 128;
`else
         oob = 1'b0;
`endif
         if (redirect_valid) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         end else if (stall) begin
         end else if (oob) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_fault = 1'b1; m_halt = 1'b1;
         end else begin
            if (flush) begin
               m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else begin
               m_instr = m_pc / 4; m_pc4 = m_pc + 4; m_valid = 1'b1;
            end
            m_pc = m_pc + 4;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("model_pc", pc, m_pc);
         chk("model_imem_addr", imem_addr, m_pc / 4);
         chk("model_instr", ifid_instr, m_instr);
         chk("model_pc4", ifid_pc4, m_pc4);
         chk("model_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
         chk("model_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic redirect_to(input logic [31:0] a);
      redirect_valid = 1'b1;
      redirect_pc = a;
      step();
      redirect_valid = 1'b0;
   endtask

   initial begin
      #1 started = 1'b1;
      @(posedge clk); #2;
      chk("reset_pc", pc, 32'h0);
      chk("reset_valid", {31'b0, ifid_valid}, 32'h0);
      chk("reset_instr", ifid_instr, 32'h0);
      chk("reset_pc4", ifid_pc4, 32'h0);
      chk("reset_fault", {31'b0, fetch_fault}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         step();
         chk("seq_instr", ifid_instr, 32'(i));
         chk("seq_pc4", ifid_pc4, 32'(4 * (i + 1)));
         chk("seq_valid", {31'b0, ifid_valid}, 32'h1);
      end
      chk("seq_pc", pc, 32'h10);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", pc, 32'h10);
         chk("stall_instr", ifid_instr, 32'h3);
         chk("stall_pc4", ifid_pc4, 32'h10);
      end
      stall = 1'b0;
      step();
      chk("resume_instr", ifid_instr, 32'h4);
      chk("resume_pc4", ifid_pc4, 32'h14);

      stall = 1'b1;
      redirect_to(32'h23);
      stall = 1'b0;
      chk("redir_pc", pc, 32'h20);
      chk("redir_valid", {31'b0, ifid_valid}, 32'h0);
      step();
      chk("redir_instr", ifid_instr, 32'h8);
      chk("redir_pc4", ifid_pc4, 32'h24);

      redirect_to(32'h08);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_valid", {31'b0, ifid_valid}, 32'h0);
      chk("flush_instr", ifid_instr, 32'h0);
      chk("flush_pc", pc, 32'h0C);
      step();
      chk("post_flush_instr", ifid_instr, 32'h3);

      // stall and flush together: stall wins, nothing moves
      stall = 1'b1; flush = 1'b1;
      step();
      stall = 1'b0; flush = 1'b0;
      chk("stall_flush_valid", {31'b0, ifid_valid}, 32'h1);
      chk("stall_flush_pc", pc, 32'h10);

      redirect_to(32'h3C);
      step();
      chk("pre_rst_pc", pc, 32'h40);
      chk("pre_rst_valid", {31'b0, ifid_valid}, 32'h1);
      rst = 1'b1;
      #1;
      chk("async_rst_pc", pc, 32'h0);
      chk("async_rst_valid", {31'b0, ifid_valid}, 32'h0);
      step();
      rst = 1'b0;
      step();
      chk("after_rst_instr", ifid_instr, 32'h0);
      chk("after_rst_valid", {31'b0, ifid_valid}, 32'h1);

`ifdef IF_RANGE_CHECK_EN
      redirect_to(32'h200);
      chk("oob_pc", pc, 32'h200);
      chk("oob_fault_early", {31'b0, fetch_fault}, 32'h0);
      step();
      chk("oob_fault", {31'b0, fetch_fault}, 32'h1);
      chk("oob_valid", {31'b0, ifid_valid}, 32'h0);
      chk("oob_pc_hold", pc, 32'h200);
      redirect_to(32'h0);
      chk("halt_ignores_redirect", pc, 32'h200);
      chk("halt_fault", {31'b0, fetch_fault}, 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("halt_rst_fault", {31'b0, fetch_fault}, 32'h0);
      chk("halt_rst_pc", pc, 32'h0);
      step();
      chk("halt_rst_valid", {31'b0, ifid_valid}, 32'h1);
`else
      redirect_to(32'hFFFF_FFFE);
      chk("wrap_pc_before", pc, 32'hFFFF_FFFC);
      step();
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_pc4", ifid_pc4, 32'h0);
      chk("wrap_instr", ifid_instr, 32'h3FFF_FFFF);
      chk("wrap_fault", {31'b0, fetch_fault}, 32'h0);
`endif

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      failures++;
      $display("FAIL timeout: got running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the word address into instruction memory.
- Captures the returned instruction, together with PC+4, into the IF/ID pipeline register for the decoder.
- Supports hazard stall, pipeline flush and branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
- IMEM_DEPTH, 128, number of 32-bit words in instruction memory; used by the range check.
- NOP_INSTR, 32'h0000_0000, bubble instruction inserted into IF/ID on squash.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- flush  input  1  replace next IF/ID contents with a bubble.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  byte target address for the redirect.
- imem_addr  output  32  word address to instruction memory, equal to {2'b00, pc[31:2]}.
- imem_data  input  32  instruction returned combinationally by instruction memory in the same cycle.
- pc  output  32  current fetch byte address.
- ifid_instr  output  32  registered instruction to decode.
- ifid_pc4  output  32  registered PC+4 of that instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- fetch_fault  output  1  out-of-range fetch detected (see Optional Feature).

Behaviour:
- Reset (async, asserts immediately):
  - pc = RESET_PC; ifid_instr = NOP_INSTR; ifid_pc4 = 0; ifid_valid = 0; fetch_fault = 0; FSM = RUN.
  - Asserting rst mid-operation discards all in-flight state.
  - First fetch of RESET_PC occurs in the first cycle after rst deasserts.
- imem_addr is purely combinational from pc: {2'b00, pc[31:2]}. Instruction memory is asynchronous-read, so imem_data is valid in the same cycle.
- Per-edge priority in RUN: rst > redirect_valid > stall > flush > normal.
- Normal (no controls asserted):
  - pc <= pc + 4.
  - ifid_instr <= imem_data; ifid_pc4 <= pc + 4; ifid_valid <= 1.
  - Latency is one cycle from PC to IF/ID.
- redirect_valid = 1:
  - pc <= {redirect_pc[31:2], 2'b00}; low two bits are ignored.
  - IF/ID squashed: ifid_instr <= NOP_INSTR, ifid_valid <= 0, ifid_pc4 <= 0.
  - Redirect overrides stall and flush in the same cycle.
- stall = 1 (no redirect): pc and all IF/ID outputs hold; flush is ignored that cycle.
- flush = 1 (no stall, no redirect): pc <= pc + 4; IF/ID gets the bubble (NOP_INSTR, valid 0, pc4 0).
- Arithmetic: pc + 4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0 with no flag.
- FSM states: RUN and HALT.
  - HALT is reachable only with the optional feature.
  - In HALT: pc frozen, ifid_valid = 0, ifid_instr = NOP_INSTR; redirect, stall and flush are ignored; the only exit is rst.

Optional Feature:
- Macro: IF_RANGE_CHECK_EN.
- Defined:
  - In RUN, if pc[31:2] >= IMEM_DEPTH at a clock edge that would capture (not stalled, not redirected), the edge instead loads the bubble, sets fetch_fault <= 1 and moves to HALT.
  - A redirect to an out-of-range target is caught on the following capture.
- Undefined:
  - No check; fetch_fault is tied to 0; the HALT state is not synthesised.

Decomposition:
- Package if_pkg holds:
  - PC_STEP = 4.
  - Default NOP_INSTR constant.
  - Fetch FSM state typedef (RUN, HALT).
  - IF/ID bundle struct (instr, pc4, valid).
- One sub-module, ifid_reg:
  - The IF/ID pipeline register.
  - Inputs: load-enable, squash, data bundle.
  - Async active-high reset to the bubble.
- instr_fetch instantiates ifid_reg and contains the PC logic and FSM.

Test Plan:
- Reset release with memory word i = i → ifid_instr follows 0, 1, 2, 3 on successive cycles; ifid_pc4 follows 4, 8, 12, 16; ifid_valid rises 1 cycle after reset release.
- Stall held 3 cycles at pc = 0x10 → pc, ifid_instr and ifid_pc4 unchanged for 3 cycles; fetch resumes with instr 4 after release.
- redirect_valid with redirect_pc = 0x23 while stall = 1 → next pc = 0x20, ifid_valid = 0; the following cycle ifid_instr = 8, ifid_pc4 = 0x24.
- flush pulse at pc = 0x08 → IF/ID holds a bubble (valid 0, instr 0); pc reaches 0x0C; next capture instr = 3.
- Assert rst mid-stream at pc = 0x40 → pc = RESET_PC and ifid_valid = 0 immediately, before the next clock edge.
- With IF_RANGE_CHECK_EN, redirect to 0x200 (word 128) → one cycle later fetch_fault = 1, ifid_valid stays 0, pc stays 0x200; a further redirect is ignored until rst.
